ubit_acc_bi: RTL and testbench
==============================

Name: ubit_acc_bi

Overview:
Downstream stage of the bipolar stochastic multiplier. It counts ones in the product bitstream over a fixed window of 2^WINLOG cycles and converts the count back into a DATAWD-bit offset-binary word. The output word uses the same encoding as the multiplier's iA/iB, so results can be reloaded into another multiplier. The result is handed off with a valid/ready handshake.

Parameters:
DATAWD, 8, width of the result word; offset-binary bipolar encoding, value = code/2^(DATAWD-1) - 1.
WINLOG, 16, log2 of the window length L = 2^WINLOG cycles. Must satisfy WINLOG >= DATAWD; elaboration fails otherwise.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, synchronous, active-high.
iBit  input  1  product bitstream from the multiplier's oC.
iStart  input  1  request to begin a new accumulation window.
iReady  input  1  consumer accepts oResult.
oResult  output  DATAWD  converted result, offset-binary.
oValid  output  1  oResult holds an unconsumed result.
oBusy  output  1  window accumulation in progress.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, oResult=0, oValid=0, oBusy=0, window counter=0, ones counter=0.
- States: IDLE, ACC, HOLD. All outputs are registered.
- IDLE:
  - oBusy=0, oValid=0.
  - iStart=1 -> ACC next cycle, window and ones counters cleared.
  - iBit on the iStart cycle is not counted.
- ACC:
  - oBusy=1. Each cycle: ones += iBit, win += 1.
  - ones is WINLOG+1 bits wide (range 0..L). win is WINLOG bits wide.
  - The cycle with win == L-1 is the last sample; exactly L bits are counted.
  - On that cycle: the result is computed from the final count, including the current iBit, and registered. State -> HOLD, so oValid=1 and oBusy=0 on the following cycle.
  - Latency: first oValid cycle = iStart cycle + L + 1.
  - iStart during ACC is ignored; no restart.
- Conversion:
  - code = ones >> (WINLOG - DATAWD).
  - If ones == L, code saturates to 2^DATAWD - 1.
  - Truncation only, no rounding.
- HOLD:
  - oValid=1, oResult stable until accepted.
  - iReady=1 and iStart=0 -> IDLE.
  - iReady=1 and iStart=1 -> ACC directly, counters cleared. Back-to-back windows have no idle gap.
  - iReady=0 -> stay in HOLD; iStart is ignored and no bits are counted.
- iReady outside HOLD has no effect.
- Reset mid-window or during HOLD: the partial count is discarded and the reset values are restored on the next edge.
- Window alignment is the user's responsibility: iStart should coincide with the multiplier load/counter restart. The full-precision product needs WINLOG = 2*DATAWD.

Decomposition:
- Shared package ubit_pkg:
  - state enum type (IDLE, ACC, HOLD);
  - function ubit_scale(ones, WINLOG, DATAWD) implementing shift plus saturation;
  - localparam helper for L.
- One natural sub-module: ubit_win_cnt, the WINLOG-bit window counter with clear/enable and a last-cycle flag. It is reusable by other converters. Everything else stays in the top module.

Test Plan:
- Saturation (DATAWD=8, WINLOG=8): iStart, iBit held 1 for 256 cycles, iReady=1 -> oResult=255, oValid one cycle at iStart+257, then IDLE.
- All zeros: iBit=0 for the window -> oResult=0. Alternating 1/0 -> oResult=128 (bipolar 0).
- Integrated with the multiplier (DATAWD=8, WINLOG=16): iA=192, iB=192 loaded at iStart -> oResult=160±1 (0.25). iA=64, iB=192 -> oResult=96±1 (-0.25).
- Backpressure: iReady=0 for 50 cycles after oValid -> oResult stable, oValid held, iStart pulses ignored. Release iReady -> IDLE.
- Back-to-back: iReady=1 with iStart=1 in HOLD -> oBusy=1 next cycle. Second result is valid exactly L+1 cycles after the acceptance cycle, and its count excludes the first window.
- Reset mid-ACC at cycle 100: all outputs and counters zero next edge. A fresh iStart with all-ones input -> oResult=255; no residue from the aborted window.

Source files
------------

// File: rtl/ubit_pkg.sv
// ---------------------------------------------------------------------------
// ubit_pkg
// Shared definitions for the unary-bitstream accumulators that sit behind the
// bipolar stochastic multiplier.
//   ubit_state_e : accumulator control states (IDLE, ACC, HOLD)
//   ubit_win_len : window length L = 2^winlog, as a 33-bit value
//   ubit_scale   : converts a ones count (0..L) into an offset-binary code
//                  of datawd bits, truncating and saturating the L count
// ---------------------------------------------------------------------------
package ubit_pkg;

    // Widest window the 33-bit helpers below can represent.
    localparam int UBIT_MAX_WINLOG = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } ubit_state_e;

    // Window length L for a given log2 size.
    function automatic logic [32:0] ubit_win_len(input int winlog);
        return 33'd1 << winlog;
    endfunction

    // Count-to-code conversion. A full window of ones would need one more
    // bit than the result word has, so it is clamped to the largest code.
    function automatic logic [31:0] ubit_scale(input logic [32:0] ones,
                                               input int          winlog,
                                               input int          datawd);
        logic [31:0] code_s;
        if (ones == ubit_win_len(winlog)) begin
            code_s = (32'd1 << datawd) - 32'd1;
        end else begin
            code_s = 32'(ones >> (winlog - datawd));
        end
        return code_s;
    endfunction

endpackage

// File: rtl/ubit_win_cnt.sv
// ---------------------------------------------------------------------------
// ubit_win_cnt
// WINLOG-bit window position counter for bitstream-to-binary converters.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, counter to zero
//   clr  : synchronous clear to zero (a new window starts next cycle)
//   en   : advance the position by one this cycle
//   last : high while enabled on the final position of the window (2^WINLOG-1)
// The counter wraps to zero after the last position, so a converter that
// stops enabling after 'last' is already aligned for its next window.
// ---------------------------------------------------------------------------
module ubit_win_cnt #(
    parameter int WINLOG = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [WINLOG-1:0] win_r;

    // Window position register: reset/clear to zero, otherwise count when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_r <= {WINLOG{1'b0}};
        end else if (clr) begin
            win_r <= {WINLOG{1'b0}};
        end else if (en) begin
            win_r <= win_r + {{(WINLOG-1){1'b0}}, 1'b1};
        end
    end

    assign last = en && (win_r == {WINLOG{1'b1}});

endmodule

// File: rtl/ubit_acc_bi.sv
// ---------------------------------------------------------------------------
// ubit_acc_bi
// Counts ones in a bipolar product bitstream over a 2^WINLOG-cycle window and
// turns the count into a DATAWD-bit offset-binary word (value = code/2^(DATAWD-1) - 1),
// the same encoding the multiplier takes on its operand inputs.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   iBit    : product bitstream sample
//   iStart  : begin a new window (honoured in IDLE, or in HOLD together with iReady)
//   iReady  : consumer takes oResult (only meaningful in HOLD)
//   oResult : converted result, offset-binary, held until accepted
//   oValid  : oResult holds an unconsumed result
//   oBusy   : window accumulation in progress
// All outputs are registered. The iBit sampled on the iStart cycle is not
// counted; exactly 2^WINLOG samples follow, and oValid rises WINLOG-window+1
// cycles after the iStart cycle.
// ---------------------------------------------------------------------------
module ubit_acc_bi
    import ubit_pkg::*;
#(
    parameter int DATAWD = 8,
    parameter int WINLOG = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iBit,
    input  logic              iStart,
    input  logic              iReady,
    output logic [DATAWD-1:0] oResult,
    output logic              oValid,
    output logic              oBusy
);

    // Parameter sanity: the shift in the conversion would go negative otherwise.
    if (WINLOG < DATAWD) begin : g_bad_winlog
        $error("ubit_acc_bi: WINLOG must be >= DATAWD");
    end
    if (WINLOG > UBIT_MAX_WINLOG) begin : g_big_winlog
        $error("ubit_acc_bi: WINLOG exceeds supported maximum");
    end

    ubit_state_e       state_r;
    logic [WINLOG:0]   ones_r;      // 0..L needs one bit more than the window counter
    logic [DATAWD-1:0] result_r;
    logic              valid_r;
    logic              busy_r;

    logic [WINLOG:0]   ones_next_s;
    logic [DATAWD-1:0] scaled_s;
    logic              start_s;
    logic              win_clr_s;
    logic              win_en_s;
    logic              win_last_s;

    // A new window opens from IDLE on iStart, or straight out of HOLD when the
    // result is taken in the same cycle a new start is requested.
    assign start_s   = ((state_r == IDLE) && iStart) ||
                       ((state_r == HOLD) && iReady && iStart);
    assign win_clr_s = start_s;
    assign win_en_s  = (state_r == ACC);

    // The last sample must be included in the result, so convert the
    // post-increment count rather than the registered one.
    assign ones_next_s = ones_r + {{WINLOG{1'b0}}, iBit};
    assign scaled_s    = DATAWD'(ubit_scale(33'(ones_next_s), WINLOG, DATAWD));

    ubit_win_cnt #(
        .WINLOG (WINLOG)
    ) u_win_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (win_clr_s),
        .en   (win_en_s),
        .last (win_last_s)
    );

    // Control FSM with ones accumulator and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            ones_r   <= {(WINLOG+1){1'b0}};
            result_r <= {DATAWD{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (iStart) begin
                        state_r <= ACC;
                        ones_r  <= {(WINLOG+1){1'b0}};
                        busy_r  <= 1'b1;
                    end
                end
                ACC: begin
                    ones_r <= ones_next_s;
                    if (win_last_s) begin
                        state_r  <= HOLD;
                        result_r <= scaled_s;
                        valid_r  <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (iReady) begin
                        valid_r <= 1'b0;
                        if (iStart) begin
                            state_r <= ACC;
                            ones_r  <= {(WINLOG+1){1'b0}};
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    ones_r   <= {(WINLOG+1){1'b0}};
                    result_r <= {DATAWD{1'b0}};
                    valid_r  <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign oResult = result_r;
    assign oValid  = valid_r;
    assign oBusy   = busy_r;

endmodule

// File: tb/tb_ubit_acc_bi.sv
// ---------------------------------------------------------------------------
// tb_ubit_acc_bi
// Self-checking bench for ubit_acc_bi with DATAWD=8, WINLOG=10 (L=1024), so
// the conversion both truncates (shift by 2) and saturates at a full window.
// Inputs change and outputs are checked on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ubit_acc_bi;

    localparam int DATAWD = 8;
    localparam int WINLOG = 10;
    localparam int WIN_L  = 1 << WINLOG;

    logic              clk;
    logic              rst;
    logic              iBit;
    logic              iStart;
    logic              iReady;
    logic [DATAWD-1:0] oResult;
    logic              oValid;
    logic              oBusy;

    int checks_cnt;
    int errors_cnt;
    int exp_code;

    ubit_acc_bi #(
        .DATAWD (DATAWD),
        .WINLOG (WINLOG)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .iBit    (iBit),
        .iStart  (iStart),
        .iReady  (iReady),
        .oResult (oResult),
        .oValid  (oValid),
        .oBusy   (oBusy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks_cnt = checks_cnt + 1;
        if (obs != exp) begin
            errors_cnt = errors_cnt + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference conversion: fraction of ones in the window mapped onto 2^DATAWD
    // codes by plain integer division, with a full window clamped to the top code.
    function automatic int ref_code(input int ones);
        int code;
        code = (ones * (1 << DATAWD)) / WIN_L;
        if (code > (1 << DATAWD) - 1) code = (1 << DATAWD) - 1;
        return code;
    endfunction

    // Bit patterns: 0 all ones, 1 all zeros, 2 alternating 1/0,
    // 3 random with density dens percent, otherwise fair coin.
    function automatic logic gen_bit(input int mode, input int i, input int dens);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (i % 2 == 0) ? 1'b1 : 1'b0;
            3:       return ($urandom_range(99, 0) < dens) ? 1'b1 : 1'b0;
            default: return 1'($urandom % 2);
        endcase
    endfunction

    // Issue a start from IDLE; the iBit on this cycle must not be counted.
    task automatic do_start();
        iStart = 1'b1;
        iBit   = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
    endtask

    // Feed one window, assuming the start edge has just occurred. Ends on the
    // falling edge where the result must be valid, with exp_code set.
    task automatic feed_window(input int mode, input string tag);
        int ones;
        int dens;
        ones = 0;
        dens = $urandom_range(100, 0);
        check_val({tag, "_busy"}, 32'(oBusy), 1);
        check_val({tag, "_nvalid"}, 32'(oValid), 0);
        for (int i = 0; i < WIN_L; i++) begin
            if (i == WIN_L - 1) begin
                check_val({tag, "_early"}, 32'(oValid), 0);
            end
            iBit   = gen_bit(mode, i, dens);
            ones   = ones + int'(iBit);
            iStart = 1'($urandom % 2);     // ignored while accumulating
            iReady = 1'($urandom % 2);     // no effect outside HOLD
            @(negedge clk);
        end
        iStart   = 1'b0;
        iReady   = 1'b0;
        iBit     = 1'b1;                   // must not be counted in HOLD
        exp_code = ref_code(ones);
        check_val({tag, "_valid"}, 32'(oValid), 1);
        check_val({tag, "_busy_end"}, 32'(oBusy), 0);
        check_val({tag, "_result"}, 32'(oResult), exp_code);
    endtask

    // Take the result without a new start; the block must return to IDLE.
    task automatic accept(input string tag);
        iReady = 1'b1;
        iStart = 1'b0;
        @(negedge clk);
        iReady = 1'b0;
        check_val({tag, "_acc_valid"}, 32'(oValid), 0);
        check_val({tag, "_acc_busy"}, 32'(oBusy), 0);
    endtask

    // Hold off the consumer; the result must stay put and starts be ignored.
    task automatic backpressure(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            iReady = 1'b0;
            iStart = 1'($urandom % 2);
            iBit   = 1'($urandom % 2);
            @(negedge clk);
            check_val("bp_valid", 32'(oValid), 1);
            check_val("bp_busy", 32'(oBusy), 0);
            check_val("bp_result", 32'(oResult), exp_code);
        end
        iStart = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        exp_code   = 0;
        rst    = 1'b1;
        iBit   = 1'b0;
        iStart = 1'b0;
        iReady = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_result", 32'(oResult), 0);
        check_val("rst_valid", 32'(oValid), 0);
        check_val("rst_busy", 32'(oBusy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Saturation, all zeros, alternating (bipolar zero).
        do_start();
        feed_window(0, "sat");
        check_val("sat_code", exp_code, 255);
        accept("sat");

        do_start();
        feed_window(1, "zero");
        check_val("zero_code", exp_code, 0);
        accept("zero");

        do_start();
        feed_window(2, "alt");
        check_val("alt_code", exp_code, 128);
        accept("alt");

        // Random window followed by 50 cycles of backpressure.
        do_start();
        feed_window(4, "rnd_bp");
        backpressure(50);
        accept("rnd_bp");

        // Back-to-back: accept and restart in the same cycle.
        do_start();
        feed_window(3, "b2b_a");
        iReady = 1'b1;
        iStart = 1'b1;
        @(negedge clk);
        iReady = 1'b0;
        iStart = 1'b0;
        feed_window(4, "b2b_b");
        accept("b2b_b");

        // Reset after 100 accumulating cycles, then fresh windows.
        do_start();
        for (int i = 0; i < 100; i++) begin
            iBit = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_result", 32'(oResult), 0);
        check_val("mid_rst_valid", 32'(oValid), 0);
        check_val("mid_rst_busy", 32'(oBusy), 0);
        @(negedge clk);
        check_val("post_rst_idle", 32'(oBusy), 0);
        do_start();
        feed_window(0, "post_rst_sat");
        check_val("post_rst_sat_code", exp_code, 255);
        accept("post_rst_sat");
        do_start();
        feed_window(3, "post_rst_rnd");
        accept("post_rst_rnd");

        // A few more random windows.
        for (int w = 0; w < 2; w++) begin
            do_start();
            feed_window(3, "rnd");
            accept("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
